// File: rtl/ps2_key_tracker_if.sv
// Bundle between a PS/2 byte source and the key tracker: byte strobe in, held-key table and event strobes out.
// Latency: none (wires only); the tracker registers every output it drives.
// Backpressure: none; key_pressed is a one-cycle strobe the tracker always accepts.
// Ports: key_pressed/in (byte strobe + scan code), keys/valid (slot table), last_code,
//        make_pulse/break_pulse/overflow/timeout (one-cycle event strobes).
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 4
);
    logic                    key_pressed;
    logic [7:0]              in;
    logic [9*NUM_KEYS-1:0]   keys;
    logic [NUM_KEYS-1:0]     valid;
    logic [8:0]              last_code;
    logic                    make_pulse;
    logic                    break_pulse;
    logic                    overflow;
    logic                    timeout;

    // master: byte source / consumer of the table
    modport master (
        output key_pressed, in,
        input  keys, valid, last_code, make_pulse, break_pulse, overflow, timeout
    );

    // slave: the key tracker
    modport slave (
        input  key_pressed, in,
        output keys, valid, last_code, make_pulse, break_pulse, overflow, timeout
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// Tracks currently held PS/2 keys in a small slot table, decoding E0/F0 prefixes.
// Latency: one cycle from the key_pressed strobe edge to every registered output.
// Backpressure: none; every strobed byte is consumed, an idle timeout clears the table.
// Ports: clock/reset (sync, active-high), bus (slave modport): key_pressed/in in,
//        keys/valid/last_code table and make/break/overflow/timeout strobes out.
module ps2_key_tracker #(
    parameter int NUM_KEYS    = 4,
    parameter int HOLD_CYCLES = 1200000,
    parameter int CNT_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    ps2_key_tracker_if.slave  bus
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [NUM_KEYS-1:0][8:0]     keys_q;
    logic [NUM_KEYS-1:0]          valid_q;
    logic [8:0]                   last_q;
    logic                         make_q, break_q, ovf_q, tmo_q;
    logic [CNT_W-1:0]             cnt_q;

    logic                         is_prefix_e0, is_prefix_f0, is_err, is_key;
    logic                         tmo_fire;
    logic                         key_ext, key_brk;
    logic [8:0]                   key_code;
    logic [NUM_KEYS-1:0]          hit_oh, free_oh;

    // Byte classification
    assign is_prefix_e0 = (bus.in == 8'hE0);
    assign is_prefix_f0 = (bus.in == 8'hF0);
    assign is_err       = (bus.in == 8'h00) || (bus.in == 8'hFF);
    assign is_key       = bus.key_pressed && !is_prefix_e0 && !is_prefix_f0 && !is_err;

    // A strobe on the terminal count wins over the timeout.
    assign tmo_fire     = !bus.key_pressed && (cnt_q == TERM);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (tmo_fire) begin
            state_d = ST_IDLE;
        end else if (bus.key_pressed) begin
            if (is_prefix_e0) begin
                case (state_q)
                    ST_IDLE: state_d = ST_EXT;
                    ST_BRK:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else if (is_prefix_f0) begin
                case (state_q)
                    ST_IDLE: state_d = ST_BRK;
                    ST_EXT:  state_d = ST_EXT_BRK;
                    default: state_d = state_q;
                endcase
            end else begin
                // error bytes and completed keys both end the sequence
                state_d = ST_IDLE;
            end
        end
    end

    // FSM: outputs (pending prefix flags applied to the current byte)
    always_comb begin
        key_ext = 1'b0;
        key_brk = 1'b0;
        case (state_q)
            ST_EXT:     key_ext = 1'b1;
            ST_BRK:     key_brk = 1'b1;
            ST_EXT_BRK: begin
                key_ext = 1'b1;
                key_brk = 1'b1;
            end
            default: ;
        endcase
    end

    assign key_code = {key_ext, bus.in};

    // Slot lookup: matching valid slot (unique by construction) and lowest free slot.
    always_comb begin
        hit_oh  = '0;
        free_oh = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (keys_q[i] == key_code)) begin
                hit_oh[i] = 1'b1;
            end
            if (!valid_q[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Table, strobes and idle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            keys_q  <= '0;
            valid_q <= '0;
            last_q  <= '0;
            make_q  <= 1'b0;
            break_q <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            make_q  <= 1'b0;
            break_q <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            if (bus.key_pressed) begin
                cnt_q <= '0;
                if (is_key) begin
                    if (!key_brk) begin
                        // a make already held is a typematic repeat: ignored
                        if (hit_oh == '0) begin
                            if (free_oh != '0) begin
                                for (int i = 0; i < NUM_KEYS; i++) begin
                                    if (free_oh[i]) begin
                                        keys_q[i] <= key_code;
                                    end
                                end
                                valid_q <= valid_q | free_oh;
                                last_q  <= key_code;
                                make_q  <= 1'b1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end else if (hit_oh != '0) begin
                        // key bits of the released slot are left in place
                        valid_q <= valid_q & ~hit_oh;
                        last_q  <= key_code;
                        break_q <= 1'b1;
                    end
                end
            end else if (tmo_fire) begin
                valid_q <= '0;
                tmo_q   <= 1'b1;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.keys        = keys_q;
    assign bus.valid       = valid_q;
    assign bus.last_code   = last_q;
    assign bus.make_pulse  = make_q;
    assign bus.break_pulse = break_q;
    assign bus.overflow    = ovf_q;
    assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a key-set model predicts every cycle's outputs.
// Latency: expected snapshot is pushed with the stimulus and checked #1 after the next edge.
// Backpressure: none; the monitor consumes one snapshot per clock.
module tb_ps2_key_tracker;
    localparam int NK   = 4;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_key_tracker_if #(.NUM_KEYS(NK)) bus ();

    ps2_key_tracker #(
        .NUM_KEYS   (NK),
        .HOLD_CYCLES(HOLD),
        .CNT_W      (8)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [9*NK-1:0] keys;
        logic [NK-1:0]   valid;
        logic [8:0]      last;
        logic            mk;
        logic            bk;
        logic            ov;
        logic            to;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    // Reference model: held keys by slot, pending prefixes, cycles since last byte.
    logic [8:0] m_key [NK];
    bit         m_vld [NK];
    logic [8:0] m_last;
    bit         m_ext, m_brk;
    int         m_idle;

    function automatic obs_t model_step(input bit r, input bit kp, input logic [7:0] b);
        obs_t       o;
        int         hit, free;
        logic [8:0] k;
        o = '0;
        if (r) begin
            for (int i = 0; i < NK; i++) begin
                m_key[i] = '0;
                m_vld[i] = 1'b0;
            end
            m_last = '0;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_idle = 0;
        end else if (kp) begin
            m_idle = 0;
            if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (b == 8'h00 || b == 8'hFF) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else begin
                k    = {m_ext, b};
                hit  = -1;
                free = -1;
                for (int i = 0; i < NK; i++)
                    if (m_vld[i] && m_key[i] == k) hit = i;
                for (int i = NK - 1; i >= 0; i--)
                    if (!m_vld[i]) free = i;
                if (!m_brk) begin
                    if (hit < 0) begin
                        if (free >= 0) begin
                            m_key[free] = k;
                            m_vld[free] = 1'b1;
                            m_last      = k;
                            o.mk        = 1'b1;
                        end else begin
                            o.ov = 1'b1;
                        end
                    end
                end else if (hit >= 0) begin
                    m_vld[hit] = 1'b0;
                    m_last     = k;
                    o.bk       = 1'b1;
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end else if (m_idle == HOLD - 1) begin
            for (int i = 0; i < NK; i++) m_vld[i] = 1'b0;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_idle = 0;
            o.to   = 1'b1;
        end else begin
            m_idle++;
        end
        for (int i = 0; i < NK; i++) begin
            o.keys[9*i +: 9] = m_key[i];
            o.valid[i]       = m_vld[i];
        end
        o.last = m_last;
        return o;
    endfunction

    task automatic step(input bit r, input bit kp, input logic [7:0] b);
        rst             = r;
        bus.key_pressed = kp;
        bus.in          = b;
        exp_q.push_back(model_step(r, kp, b));
        n_push++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        // in carries junk while idle; it must be ignored
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 8'h1C);
    endtask

    function automatic logic [7:0] pick_byte(input int sel);
        case (sel)
            0:       return 8'hE0;
            1:       return 8'hF0;
            2:       return 8'hF0;
            3:       return 8'h00;
            4:       return 8'hFF;
            5:       return 8'h1C;
            6:       return 8'h1B;
            7:       return 8'h23;
            8:       return 8'h2B;
            9:       return 8'h34;
            default: return 8'h75;
        endcase
    endfunction

    // Monitor: one registered snapshot per clock.
    obs_t act, expv;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                n_pop++;
                act = {bus.keys, bus.valid, bus.last_code, bus.make_pulse,
                       bus.break_pulse, bus.overflow, bus.timeout};
                n_checks++;
                if (act === expv) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_out t=%0t keys=%h/%h valid=%b/%b last=%h/%h mk=%b/%b bk=%b/%b ov=%b/%b to=%b/%b (actual/required)",
                             $time, act.keys, expv.keys, act.valid, expv.valid, act.last, expv.last,
                             act.mk, expv.mk, act.bk, expv.bk, act.ov, expv.ov, act.to, expv.to);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.key_pressed = 1'b0;
        bus.in          = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        do_reset();

        // Two makes fill slots 0 and 1
        send(8'h1C); idle(1); send(8'h1B); idle(2);

        // Extended make then extended break
        send(8'hE0); send(8'h75); idle(1);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);

        // Table full, overflow, typematic repeat
        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
        idle(1); send(8'h23); idle(1);
        send(8'hF0); send(8'h44); idle(1);       // break with no match

        // Idle timeout, then a strobe landing on the terminal cycle
        do_reset();
        send(8'h1C); idle(HOLD); idle(2);
        send(8'h1B); idle(HOLD - 1); send(8'h23); idle(3);

        // Reset discards a pending prefix; error byte cancels a break prefix
        send(8'hE0); do_reset(); send(8'h1C); idle(1);
        send(8'hF0); send(8'hFF); send(8'h1B); idle(1);
        send(8'hE0); send(8'h00); send(8'h75); idle(1);

        // Randomized traffic
        for (int it = 0; it < 800; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 72)      send(pick_byte($urandom_range(0, 11)));
            else if (r < 97) idle($urandom_range(1, HOLD + 4));
            else             do_reset();
        end
        idle(2);

        n_checks++;
        if (n_push == n_pop && exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain pushed=%0d popped=%0d pending=%0d", n_push, n_pop, exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
